// File: rtl/zap_fetch_fifo_pkg.sv
// Shared types and constants for the ZAP fetch FIFO: entry layout
// {abort[64], pc8[63:32], instr[31:0]} and the per-edge action decode.
package zap_fetch_fifo_pkg;

  localparam int FF_ENTRY_W   = 65;
  localparam int FF_INSTR_LSB = 0;
  localparam int FF_PC8_LSB   = 32;
  localparam int FF_ABORT_BIT = 64;

  localparam logic [31:0] ABORT_PAYLOAD = 32'd0;
  localparam logic [31:0] PC8_RESET     = 32'd8;

  // Field order matches the FF_*_LSB/BIT offsets above.
  typedef struct packed {
    logic        abort;
    logic [31:0] pc8;
    logic [31:0] instr;
  } ff_entry_t;

  typedef enum logic [1:0] {
    FF_ADVANCE = 2'd0,
    FF_HOLD    = 2'd1,
    FF_FLUSH   = 2'd2
  } ff_action_t;

  // Writeback clear beats data stall, which beats ALU clear, which beats
  // the remaining downstream stalls.
  function automatic ff_action_t ff_decode_action(
    input logic clr_wb,
    input logic data_stall,
    input logic clr_alu,
    input logic stall_any
  );
    if (clr_wb)     return FF_FLUSH;
    if (data_stall) return FF_HOLD;
    if (clr_alu)    return FF_FLUSH;
    if (stall_any)  return FF_HOLD;
    return FF_ADVANCE;
  endfunction

endpackage

// File: rtl/zap_fetch_fifo_mem.sv
// Entry storage for zap_fetch_fifo: DEPTH x FF_ENTRY_W registers with one
// synchronous write port and one asynchronous read port.
module zap_fetch_fifo_mem
  import zap_fetch_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [PTR_W-1:0]      i_wr_ptr,
  input  logic [FF_ENTRY_W-1:0] i_wr_data,
  input  logic [PTR_W-1:0]      i_rd_ptr,
  output logic [FF_ENTRY_W-1:0] o_rd_data
);

  logic [FF_ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; the parent's count and
  // pointers decide which slots hold live data, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_ptr];

endmodule

// File: rtl/zap_fetch_fifo.sv
// Instruction buffer between fetch and decode. Optional build macro
// ZAP_FETCH_FIFO_BYPASS_EN lets a word skip storage when the FIFO is empty.
module zap_fetch_fifo
  import zap_fetch_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic [31:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_instr_abort,
  input  logic [31:0] i_pc_plus_8_ff,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_pc_plus_8_ff,
  output logic        o_fetch_stall
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  ff_action_t action;
  ff_entry_t  in_entry;
  ff_entry_t  head_entry;
  logic       empty;
  logic       push_req;
  logic       pop;
  logic       bypass;
  logic       wr_en;

  assign in_entry = '{abort: i_instr_abort, pc8: i_pc_plus_8_ff, instr: i_instruction};

  assign action = ff_decode_action(
    i_clear_from_writeback,
    i_data_stall,
    i_clear_from_alu,
    i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode
  );

  // Stall comes straight off the registered count, so a word held by a
  // stalled fetch is accepted exactly once when a slot frees up.
  assign o_fetch_stall = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign push_req      = i_valid & ~o_fetch_stall;
  assign pop           = (action == FF_ADVANCE) & ~empty;

`ifdef ZAP_FETCH_FIFO_BYPASS_EN
  assign bypass = (action == FF_ADVANCE) & empty & push_req;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = push_req & (action != FF_FLUSH) & ~bypass;

  zap_fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_ptr  (wr_ptr),
    .i_wr_data (in_entry),
    .i_rd_ptr  (rd_ptr),
    .o_rd_data (head_entry)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (action == FF_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !pop) begin
        count <= count + COUNT_ONE;
      end else if (pop && !wr_en) begin
        count <= count - COUNT_ONE;
      end
    end
  end

  // Output register toward decode; pc+8 is kept across flushes and bubbles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid        <= 1'b0;
      o_instruction  <= ABORT_PAYLOAD;
      o_instr_abort  <= 1'b0;
      o_pc_plus_8_ff <= PC8_RESET;
    end else if (action == FF_FLUSH) begin
      o_valid       <= 1'b0;
      o_instruction <= ABORT_PAYLOAD;
      o_instr_abort <= 1'b0;
    end else if (action == FF_ADVANCE) begin
      if (pop) begin
        o_valid        <= 1'b1;
        o_instruction  <= head_entry.instr;
        o_instr_abort  <= head_entry.abort;
        o_pc_plus_8_ff <= head_entry.pc8;
      end else if (bypass) begin
        o_valid        <= 1'b1;
        o_instruction  <= in_entry.instr;
        o_instr_abort  <= in_entry.abort;
        o_pc_plus_8_ff <= in_entry.pc8;
      end else begin
        o_valid       <= 1'b0;
        o_instruction <= ABORT_PAYLOAD;
        o_instr_abort <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// Self-checking bench for zap_fetch_fifo: a queue-based reference model plus
// directed and randomised scenarios driven through an emulated fetch stage.
module tb_zap_fetch_fifo;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
`ifdef ZAP_FETCH_FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int LAT = BYPASS ? 1 : 2;

  typedef struct packed {
    logic        abort;
    logic [31:0] pc8;
    logic [31:0] instr;
  } word_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clear_from_writeback = 1'b0;
  logic        i_data_stall = 1'b0;
  logic        i_clear_from_alu = 1'b0;
  logic        i_stall_from_shifter = 1'b0;
  logic        i_stall_from_issue = 1'b0;
  logic        i_stall_from_decode = 1'b0;
  logic [31:0] i_instruction = '0;
  logic        i_valid = 1'b0;
  logic        i_instr_abort = 1'b0;
  logic [31:0] i_pc_plus_8_ff = '0;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic        o_instr_abort;
  logic [31:0] o_pc_plus_8_ff;
  logic        o_fetch_stall;

  always #5 i_clk = ~i_clk;

  zap_fetch_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_stall_from_decode    (i_stall_from_decode),
    .i_instruction          (i_instruction),
    .i_valid                (i_valid),
    .i_instr_abort          (i_instr_abort),
    .i_pc_plus_8_ff         (i_pc_plus_8_ff),
    .o_instruction          (o_instruction),
    .o_valid                (o_valid),
    .o_instr_abort          (o_instr_abort),
    .o_pc_plus_8_ff         (o_pc_plus_8_ff),
    .o_fetch_stall          (o_fetch_stall)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: storage queue plus the word currently shown to decode.
  word_t m_q[$];
  word_t m_out = '{abort: 1'b0, pc8: 32'd8, instr: 32'd0};
  logic  m_valid = 1'b0;

  // Emulated fetch stage and per-cycle control knobs.
  bit          fetch_run = 0;
  bit          f_has = 0;
  bit          inject_abort = 0;
  word_t       f_word = '0;
  int unsigned seq = 0;
  bit c_rst = 0, c_wb = 0, c_ds = 0, c_alu = 0, c_sh = 0, c_is = 0, c_de = 0;

  logic [66:0] act_bus;
  assign act_bus = {o_valid, o_instr_abort, o_instruction, o_pc_plus_8_ff, o_fetch_stall};

  function automatic word_t seq_word(int unsigned n);
    word_t w;
    w.abort = 1'b0;
    w.instr = 32'hE000_0000 + 32'(n);
    w.pc8   = 32'd8 + 32'(4 * (n - 1));
    return w;
  endfunction

  function automatic logic [66:0] exp_bus();
    return {m_valid, m_out.abort, m_out.instr, m_out.pc8, m_q.size() == DEPTH};
  endfunction

  // One clock edge of the FIFO, written from the behavioural rules.
  function automatic void model_edge();
    word_t in_w;
    bit push;
    bit stall_any;
    in_w      = '{abort: i_instr_abort, pc8: i_pc_plus_8_ff, instr: i_instruction};
    push      = i_valid && (m_q.size() != DEPTH);
    stall_any = i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode;
    if (i_reset) begin
      m_q.delete();
      m_valid = 1'b0;
      m_out   = '{abort: 1'b0, pc8: 32'd8, instr: 32'd0};
    end else if (i_clear_from_writeback || (!i_data_stall && i_clear_from_alu)) begin
      m_q.delete();
      m_valid     = 1'b0;
      m_out.abort = 1'b0;
      m_out.instr = 32'd0;
    end else if (i_data_stall || stall_any) begin
      if (push) m_q.push_back(in_w);
    end else if (m_q.size() != 0) begin
      m_out   = m_q.pop_front();
      m_valid = 1'b1;
      if (push) m_q.push_back(in_w);
    end else if (BYPASS && push) begin
      m_out   = in_w;
      m_valid = 1'b1;
    end else begin
      m_valid     = 1'b0;
      m_out.abort = 1'b0;
      m_out.instr = 32'd0;
      if (push) m_q.push_back(in_w);
    end
  endfunction

  // Drive one cycle from the negedge, advance model at the posedge,
  // return at the following negedge where outputs are sampled.
  task automatic cycle();
    bit full_before;
    if (!f_has && fetch_run) begin
      if (inject_abort) begin
        f_word       = '{abort: 1'b1, pc8: 32'h108, instr: 32'd0};
        inject_abort = 0;
      end else begin
        seq++;
        f_word = seq_word(seq);
      end
      f_has = 1;
    end
    i_reset                = c_rst;
    i_clear_from_writeback = c_wb;
    i_data_stall           = c_ds;
    i_clear_from_alu       = c_alu;
    i_stall_from_shifter   = c_sh;
    i_stall_from_issue     = c_is;
    i_stall_from_decode    = c_de;
    i_valid                = f_has;
    i_instruction          = f_word.instr;
    i_instr_abort          = f_word.abort;
    i_pc_plus_8_ff         = f_word.pc8;
    @(posedge i_clk);
    full_before = (m_q.size() == DEPTH);
    model_edge();
    if (c_rst || (f_has && !full_before)) f_has = 0;
    @(negedge i_clk);
  endtask

  task automatic quiet();
    {c_rst, c_wb, c_ds, c_alu, c_sh, c_is, c_de} = '0;
    fetch_run    = 0;
    inject_abort = 0;
  endtask

  task automatic do_reset();
    quiet();
    c_rst = 1;
    cycle();
    c_rst = 0;
    seq   = 0;
  endtask

  task automatic test_reset();
    quiet();
    fetch_run = 1;
    repeat (5) cycle();
    c_rst = 1;
    c_de  = 1;
    cycle();
    tests_run++;
    if (act_bus !== {1'b0, 1'b0, 32'd0, 32'd8, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h", act_bus, {1'b0, 1'b0, 32'd0, 32'd8, 1'b0});
    end
    cycle();
    tests_run++;
    if (act_bus !== exp_bus()) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", act_bus, exp_bus());
    end
    c_rst = 0;
    seq   = 0;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_run = 1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tests_run++;
      if (o_valid !== (k >= LAT)) begin
        tests_failed++;
        $display("FAIL stream_latency edge%0d: o_valid=%b expected %b", k, o_valid, k >= LAT);
      end else if (k >= LAT && (o_instruction !== 32'hE000_0000 + 32'(k - LAT + 1)
                                || o_pc_plus_8_ff !== 32'd8 + 32'(4 * (k - LAT)))) begin
        tests_failed++;
        $display("FAIL stream_order edge%0d: got %h/%h expected %h/%h", k, o_instruction,
                 o_pc_plus_8_ff, 32'hE000_0000 + 32'(k - LAT + 1), 32'd8 + 32'(4 * (k - LAT)));
      end
      tests_run++;
      if (act_bus !== exp_bus()) begin
        tests_failed++;
        $display("FAIL stream_model edge%0d: got %h expected %h", k, act_bus, exp_bus());
      end
    end
  endtask

  task automatic test_issue_stall();
    do_reset();
    fetch_run = 1;
    c_is      = 1;
    repeat (6) cycle();
    tests_run++;
    if (o_fetch_stall !== 1'b1 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL issue_stall_full: stall=%b valid=%b expected 1 0", o_fetch_stall, o_valid);
    end
    c_is = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tests_run++;
      if (o_valid !== 1'b1 || o_instruction !== 32'hE000_0000 + 32'(k)) begin
        tests_failed++;
        $display("FAIL issue_release word%0d: valid=%b instr=%h expected 1 %h", k, o_valid,
                 o_instruction, 32'hE000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_alu_clear();
    do_reset();
    fetch_run = 1;
    c_de      = 1;
    repeat (3) cycle();
    tests_run++;
    if (o_fetch_stall !== 1'b0 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_fill: stall=%b valid=%b expected 0 0", o_fetch_stall, o_valid);
    end
    c_de  = 0;
    c_alu = 1;
    cycle();
    tests_run++;
    if (o_valid !== 1'b0 || o_fetch_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_flush: valid=%b stall=%b expected 0 0", o_valid, o_fetch_stall);
    end
    c_alu     = 0;
    fetch_run = 0;
    cycle();
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_push_dropped: valid=%b expected 0", o_valid);
    end
    fetch_run = 1;
    c_de      = 1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      tests_run++;
      if (o_fetch_stall !== (k == 4) || act_bus !== exp_bus()) begin
        tests_failed++;
        $display("FAIL alu_refill%0d: got %h expected %h", k, act_bus, exp_bus());
      end
    end
    c_de = 0;
  endtask

  task automatic test_priority();
    do_reset();
    fetch_run = 1;
    repeat (3) cycle();
    fetch_run = 0;
    c_ds      = 1;
    c_alu     = 1;
    cycle();
    tests_run++;
    if (o_valid !== 1'b1 || o_instruction !== (32'hE000_0004 - 32'(LAT))) begin
      tests_failed++;
      $display("FAIL ds_over_alu: valid=%b instr=%h expected 1 %h", o_valid, o_instruction,
               32'hE000_0004 - 32'(LAT));
    end
    c_ds  = 0;
    c_alu = 0;
    cycle();
    tests_run++;
    if (act_bus !== exp_bus()) begin
      tests_failed++;
      $display("FAIL ds_no_flush: got %h expected %h", act_bus, exp_bus());
    end
    fetch_run = 1;
    c_ds      = 1;
    c_wb      = 1;
    cycle();
    tests_run++;
    if (o_valid !== 1'b0 || o_fetch_stall !== 1'b0 || o_instruction !== 32'd0) begin
      tests_failed++;
      $display("FAIL wb_over_ds: valid=%b stall=%b instr=%h expected 0 0 0", o_valid,
               o_fetch_stall, o_instruction);
    end
    c_ds      = 0;
    c_wb      = 0;
    fetch_run = 0;
    cycle();
    tests_run++;
    if (o_valid !== 1'b0 || act_bus !== exp_bus()) begin
      tests_failed++;
      $display("FAIL wb_drop: got %h expected %h", act_bus, exp_bus());
    end
  endtask

  task automatic test_abort();
    word_t loads[$];
    do_reset();
    fetch_run = 1;
    repeat (2) cycle();
    if (o_valid) loads.push_back({o_instr_abort, o_pc_plus_8_ff, o_instruction});
    inject_abort = 1;
    cycle();
    fetch_run = 0;
    if (o_valid) loads.push_back({o_instr_abort, o_pc_plus_8_ff, o_instruction});
    repeat (4) begin
      cycle();
      if (o_valid) loads.push_back({o_instr_abort, o_pc_plus_8_ff, o_instruction});
    end
    tests_run++;
    if (loads.size() != 3) begin
      tests_failed++;
      $display("FAIL abort_count: %0d words delivered, expected 3", loads.size());
    end else begin
      tests_run++;
      if (loads[0] !== seq_word(1) || loads[1] !== seq_word(2)) begin
        tests_failed++;
        $display("FAIL abort_leaders: got %h %h expected %h %h", loads[0], loads[1],
                 seq_word(1), seq_word(2));
      end
      tests_run++;
      if (loads[2] !== {1'b1, 32'h108, 32'd0}) begin
        tests_failed++;
        $display("FAIL abort_word: got %h expected %h", loads[2], {1'b1, 32'h108, 32'd0});
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned got = 0;
    int total = 3 * DEPTH + 1;
    do_reset();
    for (int cyc = 0; cyc < 300 && got < total; cyc++) begin
      fetch_run = (seq < total);
      c_de      = ($urandom_range(0, 2) == 0);
      cycle();
      if (!c_de && o_valid) begin
        tests_run++;
        if (o_instruction !== 32'hE000_0000 + 32'(got + 1)) begin
          tests_failed++;
          $display("FAIL wrap_order: got %h expected %h", o_instruction, 32'hE000_0000 + 32'(got + 1));
        end
        got++;
      end
      tests_run++;
      if (act_bus !== exp_bus()) begin
        tests_failed++;
        $display("FAIL wrap_model cyc%0d: got %h expected %h", cyc, act_bus, exp_bus());
      end
    end
    tests_run++;
    if (got != total) begin
      tests_failed++;
      $display("FAIL wrap_timeout: delivered %0d expected %0d", got, total);
    end
    quiet();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_rst        = ($urandom_range(0, 63) == 0);
      c_wb         = ($urandom_range(0, 15) == 0);
      c_ds         = ($urandom_range(0, 7) == 0);
      c_alu        = ($urandom_range(0, 15) == 0);
      c_sh         = ($urandom_range(0, 7) == 0);
      c_is         = ($urandom_range(0, 7) == 0);
      c_de         = ($urandom_range(0, 5) == 0);
      fetch_run    = ($urandom_range(0, 3) != 0);
      inject_abort = inject_abort || ($urandom_range(0, 9) == 0);
      cycle();
      tests_run++;
      if (act_bus !== exp_bus()) begin
        tests_failed++;
        $display("FAIL random_model cyc%0d: got %h expected %h", cyc, act_bus, exp_bus());
      end
    end
    quiet();
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_stream();
    test_issue_stall();
    test_alu_clear();
    test_priority();
    test_abort();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
